path_decode_stream: RTL

- Parametrised successor to the fixed 5-bit/20-slot path decoder.
- Reconstructs the shortest path from a solver's predecessor table: walks from end_node back to st_node through a 1-cycle-latency read port, buffers the nodes, then presents the path start-first.
- Two outputs: a packed vector for legacy consumers, and a valid/ready stream for the motion planner.
- Adds error detection for unreachable nodes and over-long paths.

---
 rtl/path_decode_stream.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/path_decode_stream.sv
// Shortest-path reconstruction from a predecessor table.
// Walks end_node -> st_node through a 1-cycle-latency read port, buffers the
// visited nodes, then publishes the path start-first on a packed vector and on
// a valid/ready stream. Unreachable nodes, loops and over-long paths pulse err.
//
// Stream handshake: out_valid is high for the whole STREAM state; a beat
// transfers on a rising edge where out_valid && out_ready; out_node/out_last
// only change after a transfer, so they hold stable while out_ready is low.
module path_decode_stream #(
    parameter int                NODE_W  = 5,
    parameter int                MAX_LEN = 20,
    parameter logic [NODE_W-1:0] FILL    = {NODE_W{1'b1}}
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [NODE_W-1:0]              st_node,
    input  logic [NODE_W-1:0]              end_node,
    output logic                           busy,
    output logic                           pred_rd,
    output logic [NODE_W-1:0]              pred_addr,
    input  logic [NODE_W-1:0]              pred_data,
    input  logic                           pred_has,
    output logic [MAX_LEN*NODE_W-1:0]      path_o,
    output logic [$clog2(MAX_LEN+1)-1:0]   path_len,
    output logic                           done,
    output logic                           err,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NODE_W-1:0]              out_node,
    output logic                           out_last,
    output logic [2:0]                     state_dbg
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int PW    = MAX_LEN * NODE_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WALK   = 3'd1,
        S_WAIT   = 3'd2,
        S_LOAD   = 3'd3,
        S_STREAM = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [NODE_W-1:0] st_q;
    logic [NODE_W-1:0] cur_q, cur_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  rp_q, rp_d;
    logic [NODE_W-1:0] node_buf [MAX_LEN];
    logic              buf_we;
    logic              path_we;
    logic [PW-1:0]     path_d;
    logic [LEN_W-1:0]  len_d;
    logic [PW-1:0]     walk_path;
    logic [PW-1:0]     fill_vec;
    logic              at_src;
    logic              at_max;
    logic              loop_hit;

    assign fill_vec  = {MAX_LEN{FILL}};
    assign at_src    = (cur_q == st_q);
    assign at_max    = (idx_q == IDX_W'(MAX_LEN - 1));
    assign state_dbg = state_q;

    // Loop detection: does the returned predecessor already sit in buf[0..idx]?
    always_comb begin
        loop_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i <= int'(idx_q) && node_buf[i] == pred_data) begin
                loop_hit = 1'b1;
            end
        end
    end

    // Start-first path assembled while the source node is still in cur_q, so
    // path_o/path_len are already valid during the LOAD (done) cycle.
    always_comb begin
        walk_path = fill_vec;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (k == 0) begin
                walk_path[k*NODE_W +: NODE_W] = cur_q;
            end else if (k <= int'(idx_q)) begin
                walk_path[k*NODE_W +: NODE_W] = node_buf[IDX_W'(int'(idx_q) - k)];
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        idx_d     = idx_q;
        rp_d      = rp_q;
        buf_we    = 1'b0;
        path_we   = 1'b0;
        path_d    = walk_path;
        len_d     = LEN_W'(idx_q) + LEN_W'(1);
        busy      = (state_q != S_IDLE);
        pred_rd   = 1'b0;
        pred_addr = '0;
        done      = 1'b0;
        err       = 1'b0;
        out_valid = 1'b0;
        out_node  = '0;
        out_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_d   = end_node;
                    idx_d   = '0;
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                buf_we = 1'b1;
                if (at_src) begin
                    path_we = 1'b1;
                    rp_d    = idx_q;
                    state_d = S_LOAD;
                end else if (at_max) begin
                    path_we = 1'b1;
                    path_d  = fill_vec;
                    len_d   = '0;
                    state_d = S_FAIL;
                end else begin
                    pred_rd   = 1'b1;
                    pred_addr = cur_q;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!pred_has || loop_hit) begin
                    path_we = 1'b1;
                    path_d  = fill_vec;
                    len_d   = '0;
                    state_d = S_FAIL;
                end else begin
                    cur_d   = pred_data;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_WALK;
                end
            end
            S_LOAD: begin
                done    = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                out_valid = 1'b1;
                out_node  = node_buf[rp_q];
                out_last  = (rp_q == '0);
                if (out_ready) begin
                    if (rp_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        rp_d = rp_q - IDX_W'(1);
                    end
                end
            end
            S_FAIL: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, walk registers and published result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            st_q     <= '0;
            cur_q    <= '0;
            idx_q    <= '0;
            rp_q     <= '0;
            path_o   <= {MAX_LEN{FILL}};
            path_len <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
            rp_q    <= rp_d;
            if (state_q == S_IDLE && start) begin
                st_q <= st_node;
            end
            if (path_we) begin
                path_o   <= path_d;
                path_len <= len_d;
            end
        end
    end

    // Node buffer; entries above idx are stale and never read.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            node_buf[idx_q] <= cur_q;
        end
    end

endmodule
